dpram_rw_ctrl: RTL and testbench

Synchronous access controller wrapping the 1024×16 internal dual-port RAM. It sits directly downstream of the user/self-test I/O stage. That stage drives `RD`/`WR` request levels with `A` and `DIn`; this block latches the request, performs the single-port access, and returns `DOut` plus a `Done` handshake. The `Done` handshake is held until the requester drops its request.

---
 rtl/dpram_rw_ctrl.sv | 157 +++++++++++++++
 tb/tb_dpram_rw_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dpram_rw_ctrl.sv
// dpram_rw_ctrl
// Access controller for the 2^AW x DW internal dual-port RAM. It accepts
// level-style RD/WR requests, latches address and data on acceptance, performs
// one access and holds Done until both requests drop.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a rising edge on RD or WR
// WR_EX | write mem[a_q] <= d_q
// RD_AD | load RAM output register from mem[a_q]
// RD_DA | transfer RAM output register to DOut
// HOLD  | Done asserted, waiting for RD and WR both low
// ERR   | RD and WR rose together, Err asserted until both low
//
// Ports:
//   clk   in          system clock, rising edge
//   ar    in          asynchronous active-low reset
//   RD    in          read request level
//   WR    in          write request level
//   A     in  [AW]    word address, sampled on acceptance
//   DIn   in  [DW]    write data, sampled on acceptance
//   DOut  out [DW]    last read data
//   Done  out         access complete, held until RD and WR low
//   Busy  out         controller not in IDLE
//   Err   out         simultaneous RD/WR rise, held until both low
module dpram_rw_ctrl #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          ar,
  input  logic          RD,
  input  logic          WR,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] DIn,
  output logic [DW-1:0] DOut,
  output logic          Done,
  output logic          Busy,
  output logic          Err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_EXEC = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_HOLD    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          rd_q, wr_q;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] dout_q, dout_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          mem_we, ram_re;
  logic          rd_rise, wr_rise;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  assign rd_rise = RD & ~rd_q;
  assign wr_rise = WR & ~wr_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    dout_d  = dout_q;
    done_d  = done_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_rise && wr_rise) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (wr_rise) begin
          state_d = S_WR_EXEC;
          a_d     = A;
          d_d     = DIn;
        end else if (rd_rise) begin
          state_d = S_RD_ADDR;
          a_d     = A;
        end
      end
      S_WR_EXEC: begin
        mem_we  = 1'b1;
        done_d  = 1'b1;
        state_d = S_HOLD;
      end
      S_RD_ADDR: begin
        ram_re  = 1'b1;
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        dout_d  = ram_q;
        done_d  = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!(RD || WR)) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (!(RD || WR)) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Edge-detect registers reset high so a request already asserted at
  // reset release must drop and rise again before it is accepted.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      a_q     <= '0;
      d_q     <= '0;
      ram_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= RD;
      wr_q    <= WR;
      a_q     <= a_d;
      d_q     <= d_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (ram_re) ram_q <= mem[a_q];
    end
  end

  // RAM contents are deliberately not reset; the write enable comes from
  // state, so a reset before the write edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[a_q] <= d_q;
  end

  assign DOut = dout_q;
  assign Done = done_q;
  assign Err  = err_q;
  assign Busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_dpram_rw_ctrl.sv
module tb_dpram_rw_ctrl;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk;
  logic          ar;
  logic          RD, WR;
  logic [AW-1:0] A;
  logic [DW-1:0] DIn;
  logic [DW-1:0] DOut;
  logic          Done, Busy, Err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain word array plus the last value a read returned.
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  bit            model_known [0:(1<<AW)-1];
  logic [DW-1:0] model_dout;

  dpram_rw_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .ar  (ar),
    .RD  (RD),
    .WR  (WR),
    .A   (A),
    .DIn (DIn),
    .DOut(DOut),
    .Done(Done),
    .Busy(Busy),
    .Err (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one request, returns what was observed. Inputs change on negedges;
  // the first negedge after the request is set follows the sampling edge k.
  task automatic access(input bit is_wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [AW-1:0] a_after,
                        input int hold, output int lat, output logic [DW-1:0] dout,
                        output bit held_ok, output logic done_rel,
                        output logic busy_rel, output logic busy_first);
    @(negedge clk);
    A = addr; DIn = data; WR = is_wr; RD = !is_wr;
    lat = 0;
    busy_first = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        busy_first = Busy;
        A = a_after;
        DIn = ~data;
      end
    end while (Done !== 1'b1 && lat < 12);
    dout = DOut;
    held_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (Done !== 1'b1 || DOut !== dout) held_ok = 1'b0;
    end
    RD = 1'b0; WR = 1'b0;
    @(negedge clk);
    done_rel = Done;
    busy_rel = Busy;
  endtask

  task automatic test_reset();
    ar = 1'b1; RD = 1'b1; WR = 1'b0; A = '0; DIn = '0;
    #3 ar = 1'b0;
    #1;
    vectors++; if (DOut !== 16'h0) begin miscompares++; $display("FAIL reset_dout: got %h want 0000", DOut); end
    vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", Done); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", Busy); end
    vectors++; if (Err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", Err); end
    repeat (2) @(negedge clk);
    ar = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vectors++; if (Busy !== 1'b0 || Done !== 1'b0) begin miscompares++; $display("FAIL reset_rd_held: busy=%b done=%b want 0 0", Busy, Done); end
    end
    RD = 1'b0;
    @(negedge clk);
    model_dout = '0;
  endtask

  task automatic test_write();
    int lat; logic [DW-1:0] d; bit h; logic dr, br, bf;
    access(1'b1, 10'h2A5, 16'hBEEF, 10'h000, 2, lat, d, h, dr, br, bf);
    model_mem[10'h2A5] = 16'hBEEF; model_known[10'h2A5] = 1'b1;
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL write_latency: got %0d want 2", lat); end
    vectors++; if (bf !== 1'b1) begin miscompares++; $display("FAIL write_busy: got %b want 1", bf); end
    vectors++; if (!h) begin miscompares++; $display("FAIL write_done_held: got 0 want 1"); end
    vectors++; if (dr !== 1'b0 || br !== 1'b0) begin miscompares++; $display("FAIL write_release: done=%b busy=%b want 0 0", dr, br); end
    vectors++; if (d !== model_dout) begin miscompares++; $display("FAIL write_dout_kept: got %h want %h", d, model_dout); end
  endtask

  task automatic test_read();
    int lat; logic [DW-1:0] d; bit h; logic dr, br, bf;
    access(1'b0, 10'h2A5, 16'h0000, 10'h000, 1, lat, d, h, dr, br, bf);
    model_dout = model_mem[10'h2A5];
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL read_latency: got %0d want 3", lat); end
    vectors++; if (d !== 16'hBEEF) begin miscompares++; $display("FAIL read_data: got %h want beef", d); end
    vectors++; if (!h) begin miscompares++; $display("FAIL read_done_held: got 0 want 1"); end
    vectors++; if (dr !== 1'b0 || br !== 1'b0) begin miscompares++; $display("FAIL read_release: done=%b busy=%b want 0 0", dr, br); end
  endtask

  task automatic test_boundary();
    int lat; logic [DW-1:0] d; bit h; logic dr, br, bf;
    access(1'b1, 10'h000, 16'h1234, 10'h3FF, 0, lat, d, h, dr, br, bf);
    model_mem[10'h000] = 16'h1234; model_known[10'h000] = 1'b1;
    access(1'b1, 10'h3FF, 16'hABCD, 10'h000, 0, lat, d, h, dr, br, bf);
    model_mem[10'h3FF] = 16'hABCD; model_known[10'h3FF] = 1'b1;
    access(1'b0, 10'h000, 16'h0, 10'h3FF, 0, lat, d, h, dr, br, bf);
    vectors++; if (d !== 16'h1234) begin miscompares++; $display("FAIL bound_lo: got %h want 1234", d); end
    access(1'b0, 10'h3FF, 16'h0, 10'h000, 0, lat, d, h, dr, br, bf);
    model_dout = 16'hABCD;
    vectors++; if (d !== 16'hABCD) begin miscompares++; $display("FAIL bound_hi: got %h want abcd", d); end
  endtask

  task automatic test_err();
    int lat; logic [DW-1:0] d; bit h; logic dr, br, bf;
    @(negedge clk);
    A = 10'h2A5; DIn = 16'h5A5A; RD = 1'b1; WR = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++; if (Err !== 1'b1 || Done !== 1'b0 || Busy !== 1'b1) begin miscompares++; $display("FAIL err_state: err=%b done=%b busy=%b want 1 0 1", Err, Done, Busy); end
    end
    RD = 1'b0; WR = 1'b0;
    @(negedge clk);
    vectors++; if (Err !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("FAIL err_clear: err=%b busy=%b want 0 0", Err, Busy); end
    access(1'b0, 10'h2A5, 16'h0, 10'h2A5, 0, lat, d, h, dr, br, bf);
    model_dout = model_mem[10'h2A5];
    vectors++; if (d !== model_mem[10'h2A5]) begin miscompares++; $display("FAIL err_ram_unchanged: got %h want %h", d, model_mem[10'h2A5]); end
  endtask

  task automatic test_rd_pulse();
    int lat; logic [DW-1:0] d; bit h; logic dr, br, bf;
    @(negedge clk);
    A = 10'h000; RD = 1'b1;
    @(negedge clk);             // after edge k: read in flight
    RD = 1'b0; WR = 1'b1; A = 10'h3FF; DIn = 16'hDEAD;
    @(negedge clk);
    WR = 1'b0;
    @(negedge clk);             // after edge k+2
    model_dout = model_mem[10'h000];
    vectors++; if (Done !== 1'b1 || DOut !== model_dout) begin miscompares++; $display("FAIL pulse_done: done=%b dout=%h want 1 %h", Done, DOut, model_dout); end
    @(negedge clk);
    vectors++; if (Done !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("FAIL pulse_one_cycle: done=%b busy=%b want 0 0", Done, Busy); end
    access(1'b0, 10'h3FF, 16'h0, 10'h000, 0, lat, d, h, dr, br, bf);
    model_dout = model_mem[10'h3FF];
    vectors++; if (d !== model_mem[10'h3FF]) begin miscompares++; $display("FAIL pulse_wr_ignored: got %h want %h", d, model_mem[10'h3FF]); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [DW-1:0] d; bit h; logic dr, br, bf;
    @(negedge clk);
    A = 10'h000; DIn = 16'h5555; WR = 1'b1;
    @(negedge clk);             // after edge k, write not yet done
    ar = 1'b0; WR = 1'b0;
    #1;
    vectors++; if (DOut !== 16'h0 || Done !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("FAIL midreset_async: dout=%h done=%b busy=%b want 0000 0 0", DOut, Done, Busy); end
    @(negedge clk);
    ar = 1'b1;
    model_dout = '0;
    @(negedge clk);
    access(1'b0, 10'h000, 16'h0, 10'h155, 0, lat, d, h, dr, br, bf);
    model_dout = model_mem[10'h000];
    vectors++; if (d !== model_mem[10'h000]) begin miscompares++; $display("FAIL midreset_no_write: got %h want %h", d, model_mem[10'h000]); end
  endtask

  task automatic test_random();
    int lat; logic [DW-1:0] d; bit h; logic dr, br, bf;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit is_wr;
    int hold;
    for (int n = 0; n < 60; n++) begin
      addr = AW'(($urandom_range(0, 7) * 131) % 1024);
      data = DW'($urandom);
      is_wr = ($urandom_range(0, 1) == 1) || !model_known[addr];
      hold = $urandom_range(0, 3);
      access(is_wr, addr, data, AW'($urandom), hold, lat, d, h, dr, br, bf);
      if (is_wr) begin
        model_mem[addr] = data; model_known[addr] = 1'b1;
        vectors++; if (lat !== 2 || d !== model_dout) begin miscompares++; $display("FAIL rand_write: lat=%0d dout=%h want 2 %h", lat, d, model_dout); end
      end else begin
        model_dout = model_mem[addr];
        vectors++; if (lat !== 3 || d !== model_dout) begin miscompares++; $display("FAIL rand_read @%h: lat=%0d dout=%h want 3 %h", addr, lat, d, model_dout); end
      end
      vectors++; if (!h || dr !== 1'b0 || br !== 1'b0 || bf !== 1'b1) begin miscompares++; $display("FAIL rand_handshake: held=%0d done=%b busy=%b busy1=%b want 1 0 0 1", h, dr, br, bf); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) model_known[i] = 1'b0;
    model_dout = '0;
    test_reset();
    test_write();
    test_read();
    test_boundary();
    test_err();
    test_rd_pulse();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
